// File: rtl/dmem_pkg.sv
// Shared types and constants for the memory-stage data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int DMEM_WORD_BYTES = 4;
  localparam int DMEM_CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, synchronous registered read.
// The read register holds its value until the next read enable.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with pipeline stall for the memory stage.
// Optional misaligned-access rejection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OFS_W = $clog2(DMEM_WORD_BYTES);
  localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
    (LATENCY > 1) ? DMEM_CNT_W'(LATENCY - 2) : '0;

  dmem_state_t           state_q;
  logic [DMEM_CNT_W-1:0] cnt_q;
  logic                  rdata_valid_q;
  logic                  err_q;

  logic                  we_q;
  logic                  bad_q;
  logic [AW-1:0]         idx_q;
  logic [31:0]           wdata_q;

  logic                  addr_bad;
  logic                  idle_acc;
  logic                  go;
  logic                  acc_we;
  logic                  acc_bad;
  logic [AW-1:0]         acc_idx;
  logic [31:0]           acc_wdata;
  logic                  arr_we;
  logic                  arr_re;
  logic                  unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_bad = |addr[OFS_W-1:0];
`else
  assign addr_bad = 1'b0;
`endif

  assign unused_addr = ^{addr[31:AW+OFS_W], addr[OFS_W-1:0]};

  assign idle_acc = (state_q == IDLE) && req;
  // With LATENCY=1 the access commits on the same edge that accepts it,
  // so the array is fed straight from the request rather than the capture.
  assign go = (idle_acc && (LATENCY == 1)) ||
              ((state_q == WAIT) && (cnt_q == '0));

  assign acc_we    = (state_q == IDLE) ? mem_w_en : we_q;
  assign acc_bad   = (state_q == IDLE) ? addr_bad : bad_q;
  assign acc_idx   = (state_q == IDLE) ? addr[AW+OFS_W-1:OFS_W] : idx_q;
  assign acc_wdata = (state_q == IDLE) ? wdata : wdata_q;

  assign arr_we = go && acc_we && !acc_bad;
  assign arr_re = go && !acc_we && !acc_bad;

  assign stall       = idle_acc || (state_q == WAIT);
  assign rdata_valid = rdata_valid_q;
  assign err         = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rdata_valid_q <= arr_re;
      err_q         <= go && acc_bad;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (LATENCY == 1) begin
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - DMEM_CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request fields are sampled only at acceptance; the requester may not be trusted afterwards.
  always_ff @(posedge clk) begin
    if (idle_acc) begin
      we_q    <= mem_w_en;
      bad_q   <= addr_bad;
      idx_q   <= addr[AW+OFS_W-1:OFS_W];
      wdata_q <= wdata;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven accesses on a LATENCY=2 instance
// plus hand-written sequences on LATENCY=1 and LATENCY=4 instances.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst4;

  logic        req, we, stall, valid, err;
  logic [31:0] addr, wdata, rdata;
  logic        req1, we1, stall1, valid1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        req4, we4, stall4, valid4, err4;
  logic [31:0] addr4, wdata4, rdata4;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .mem_w_en(we), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(valid), .err(err)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req(req1), .mem_w_en(we1), .addr(addr1), .wdata(wdata1),
    .stall(stall1), .rdata(rdata1), .rdata_valid(valid1), .err(err1)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst4), .req(req4), .mem_w_en(we4), .addr(addr4), .wdata(wdata4),
    .stall(stall4), .rdata(rdata4), .rdata_valid(valid4), .err(err4)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        valid;
    logic        err;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one access on the LATENCY=2 instance and checks it at its DONE cycle.
  task automatic run_main(input logic w, input logic [31:0] a, input logic [31:0] d);
    int   n;
    exp_t e;
    n     = 0;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("main_stall_cycles", 32'(n), 32'd2);
    e = sb.pop_front();
    chk("main_done_stall", {31'd0, stall}, 32'd0);
    chk("main_rdata", rdata, e.rdata);
    chk("main_valid", {31'd0, valid}, {31'd0, e.valid});
    chk("main_err", {31'd0, err}, {31'd0, e.err});
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [31:0] stab_exp;
    logic exp_s, exp_v;

    vecs[0] = '{1'b1, 32'h40,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h40,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h1000, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,    32'h0,        32'hCAFEF00D, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h40,   32'hA5A5A5A5, 32'hCAFEF00D, 1'b0, 1'b0};
    if (ALIGN) begin
      vecs[5] = '{1'b0, 32'h41, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 32'h42, 32'h11111111, 32'hCAFEF00D, 1'b0, 1'b1};
      vecs[7] = '{1'b0, 32'h40, 32'h0,        32'hA5A5A5A5, 1'b1, 1'b0};
      stab_exp = 32'hA5A5A5A5;
    end else begin
      vecs[5] = '{1'b0, 32'h41, 32'h0,        32'hA5A5A5A5, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 32'h42, 32'h11111111, 32'hA5A5A5A5, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 32'h40, 32'h0,        32'h11111111, 1'b1, 1'b0};
      stab_exp = 32'h11111111;
    end
    vecs[8] = '{1'b1, 32'hFFC,  32'h0BADF00D, stab_exp,     1'b0, 1'b0};
    vecs[9] = '{1'b0, 32'h1FFC, 32'h0,        32'h0BADF00D, 1'b1, 1'b0};

    rst = 1'b1; rst4 = 1'b1;
    req = 1'b0;  we = 1'b0;  addr = '0;  wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    req4 = 1'b0; we4 = 1'b0; addr4 = '0; wdata4 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      sb.push_back('{vecs[i].exp_rdata, vecs[i].exp_valid, vecs[i].exp_err});
      run_main(vecs[i].we, vecs[i].addr, vecs[i].wdata);
    end

    // Address changes while stalled; the captured address must be used.
    req = 1'b1; we = 1'b0; addr = 32'h40;
    @(posedge clk); #1;
    addr = 32'h1000;
    n = 0;
    @(negedge clk);
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("stable_rdata", rdata, stab_exp);
    chk("stable_valid", {31'd0, valid}, 32'd1);
    req = 1'b0;
    @(posedge clk); #1;

    // LATENCY=1: one store, then three loads with req held high.
    req1 = 1'b1; we1 = 1'b1; wdata1 = 32'h600DCAFE;
    @(posedge clk); #1;
    req1 = 1'b0; we1 = 1'b0;
    @(posedge clk); #1;
    req1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_s = (c % 2 == 0);
      exp_v = (c % 2 == 1);
      chk($sformatf("l1_stall_c%0d", c), {31'd0, stall1}, {31'd0, exp_s});
      chk($sformatf("l1_valid_c%0d", c), {31'd0, valid1}, {31'd0, exp_v});
      if (exp_v) chk($sformatf("l1_rdata_c%0d", c), rdata1, 32'h600DCAFE);
      @(posedge clk); #1;
    end
    req1 = 1'b0;
    @(negedge clk);
    chk("l1_err", {31'd0, err1}, 32'd0);
    @(posedge clk); #1;

    // LATENCY=4: commit prior contents, then abort a store with reset mid-WAIT.
    req4 = 1'b1; we4 = 1'b1; addr4 = 32'h80; wdata4 = 32'h55AA55AA;
    n = 0;
    @(negedge clk);
    while (stall4 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("l4_stall_cycles", 32'(n), 32'd4);
    req4 = 1'b0;
    @(posedge clk); #1;
    req4 = 1'b1; we4 = 1'b1; wdata4 = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4 = 1'b1; req4 = 1'b0; we4 = 1'b0;
    @(posedge clk); #1;
    rst4 = 1'b0;
    @(negedge clk);
    chk("l4_abort_stall", {31'd0, stall4}, 32'd0);
    chk("l4_abort_rdata", rdata4, 32'd0);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (valid4 || err4) n++;
      @(negedge clk);
    end
    chk("l4_abort_no_pulse", 32'(n), 32'd0);
    @(posedge clk); #1;
    req4 = 1'b1; we4 = 1'b0; addr4 = 32'h80;
    n = 0;
    @(negedge clk);
    while (stall4 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("l4_load_rdata", rdata4, 32'h55AA55AA);
    chk("l4_load_valid", {31'd0, valid4}, 32'd1);
    req4 = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
